fa4_serial_add_ctrl: RTL and testbench
======================================

// Module: fa4_serial_add_ctrl
// PURPOSE
//  Sequencer that reuses one 4-bit full-adder slice (FA4) to add WIDTH-bit operands one nibble per clock.
//  - LSB nibble first; carry is registered between nibbles.
//  - Provides a start/busy/done handshake so a host FSM can issue wide adds without a WIDTH-bit ripple chain.
//  - Sits between the host datapath and a single FA4 instance.
// PARAMETERS
//  WIDTH    16           operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//  NIB      WIDTH/4      derived nibble count (localparam, not overridable)
// PORTS
//  clk      in   1       single clock, rising edge
//  reset    in   1       synchronous, active-high
//  start    in   1       request; accepted only on an edge where busy==0
//  A        in   WIDTH   operand A, sampled on the accepting edge
//  B        in   WIDTH   operand B, sampled on the accepting edge
//  Ci       in   1       carry-in, sampled on the accepting edge
//  busy     out  1       high while an add is in progress
//  done     out  1       one-cycle pulse; Y/Co valid from this cycle
//  Y        out  WIDTH   result, held until the next completion
//  Co       out  1       final carry-out, held with Y
// BEHAVIOUR
//  - Reset (sync, any state, including mid-operation):
//    state=IDLE, busy=0, done=0, Y=0, Co=0, nibble counter=0, carry reg=0; partial result discarded.
//  - States: IDLE -> RUN -> IDLE. No separate DONE state; done is a registered pulse.
//  - IDLE: on the edge with start=1, latch A, B, Ci into operand regs; cnt=0; go to RUN; busy=1 after that edge.
//  - RUN, cycle k (k=0..NIB-1):
//    - FA4 sees A[4k+3:4k], B[4k+3:4k], Ci=carry_reg (k=0: latched Ci).
//    - At the next edge: FA4 Y goes to shadow[4k+3:4k], FA4 Co goes to carry_reg, cnt increments.
//  - Completion (edge ending cycle k=NIB-1):
//    - Y<=shadow with the last nibble merged; Co<=FA4 Co; done<=1; busy<=0; state=IDLE.
//    - Y and Co update atomically, only at completion; never show partial results.
//  - Latency: start accepted at edge t -> done high and busy low in the cycle after edge t+NIB. Throughput: 1 add per NIB cycles.
//  - start while busy=1: ignored, no queueing, no error flag.
//  - start=1 in the done cycle: accepted (busy=0); back-to-back adds with zero idle cycles.
//  - done is high for exactly one cycle per accepted start. With start held, the next done follows NIB cycles later.
//  - Arithmetic: {Co,Y} = A + B + Ci modulo 2^(WIDTH+1), unsigned.
//  - Input changes on A/B/Ci after acceptance have no effect on the running add.
// CONFIGURATION
//  - FA4_SUB_EN defined:
//    - Adds input port sub (1 bit), sampled with the operands.
//    - sub=1 means B is inverted nibble-wise before FA4 and Ci is forced to 1, so Y = A - B. The Ci port is ignored.
//    - Co=1 means no borrow.
//    - sub=0 is identical to the non-SUB build.
//  - FA4_SUB_EN undefined: no sub port; addition only.
// STRUCTURE
//  - Shared package fa4_pkg:
//    - localparam NIBBLE_W=4.
//    - State typedef/encoding: ST_IDLE=1'b0, ST_RUN=1'b1.
//    - Function clog2 for the counter width: max(1, clog2(NIB)).
//  - One sub-module: the existing FA4 slice (ports A, B, Ci, Y, Co), instantiated once.
//  - Nibble select by cnt-indexed part-select.
//  - No other hierarchy.
// TESTING
//  - WIDTH=16: A=16'hFFFF, B=16'h0001, Ci=0 -> done 4 cycles after accept, Y=16'h0000, Co=1, busy high for exactly 4 cycles.
//  - A=16'h1234, B=16'h4321, Ci=1 -> Y=16'h5556, Co=0. Y stays 0 or the previous value until done.
//  - start held high for 3 ops (A=1/2/3, B=1, Ci=0) -> done pulses 4 cycles apart; Y=2,3,4 on successive done cycles.
//  - start pulsed again 2 cycles into a run with different operands -> ignored; result matches the first operands only.
//  - reset asserted 2 cycles into a run -> next edge busy=0, done=0, Y=0, Co=0. New start then completes normally.
//  - 1000 random A/B/Ci at WIDTH=16 and WIDTH=4 (NIB=1, done 1 cycle after accept) vs model {Co,Y}==A+B+Ci.
//    With FA4_SUB_EN: sub=1, A=16'h0005, B=16'h0007 -> Y=16'hFFFE, Co=0.

Source files
------------

// File: rtl/fa4_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
package fa4_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Counter width for n nibbles; never narrower than one bit.
    function automatic int cnt_w(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << w) < n) w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fa4_serial_add_ctrl_if.sv
// Host-side handshake and operand/result bus of the serial adder.
// The sub signal exists only when FA4_SUB_EN is defined.
interface fa4_serial_add_ctrl_if #(parameter int WIDTH = 16);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
`ifdef FA4_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Y;
    logic             Co;

`ifdef FA4_SUB_EN
    modport master (output start, A, B, Ci, sub, input busy, done, Y, Co);
    modport slave  (input start, A, B, Ci, sub, output busy, done, Y, Co);
`else
    modport master (output start, A, B, Ci, input busy, done, Y, Co);
    modport slave  (input start, A, B, Ci, output busy, done, Y, Co);
`endif

endinterface

// File: rtl/fa4_serial_add_ctrl_fa4.sv
// The shared 4-bit full-adder slice.
module fa4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Ci,
    output logic [3:0] Y,
    output logic       Co
);

    assign {Co, Y} = {1'b0, A} + {1'b0, B} + {4'b0000, Ci};

endmodule

// File: rtl/fa4_serial_add_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one fa4 slice, LSB nibble first.
// Optional subtract mode is built when FA4_SUB_EN is defined.
module fa4_serial_add_ctrl
    import fa4_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                clk,
    input  logic                reset,
    fa4_serial_add_ctrl_if.slave bus
);

    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int CW  = cnt_w(NIB);
    localparam int IW  = CW + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(NIB - 1);

    if (((WIDTH % NIBBLE_W) != 0) || (WIDTH < NIBBLE_W)) begin : g_bad_width
        $error("fa4_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             co_q, co_d;
    logic             done_q, done_d;

    logic [IW-1:0]       nib_lsb;
    logic [NIBBLE_W-1:0] fa_a, fa_b, fa_y;
    logic                fa_co;
    logic [WIDTH-1:0]    merged;
    logic [WIDTH-1:0]    b_in;
    logic                ci_in;

    assign nib_lsb = {cnt_q, 2'b00};
    assign fa_a    = a_q[nib_lsb +: NIBBLE_W];
    assign fa_b    = b_q[nib_lsb +: NIBBLE_W];

    fa4 u_fa4 (
        .A  (fa_a),
        .B  (fa_b),
        .Ci (carry_q),
        .Y  (fa_y),
        .Co (fa_co)
    );

    // Subtraction is A + ~B + 1, folded into the operand latch.
`ifdef FA4_SUB_EN
    assign b_in  = bus.sub ? ~bus.B : bus.B;
    assign ci_in = bus.sub ? 1'b1 : bus.Ci;
`else
    assign b_in  = bus.B;
    assign ci_in = bus.Ci;
`endif

    always_comb begin
        merged                     = shadow_q;
        merged[nib_lsb +: NIBBLE_W] = fa_y;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        shadow_d = shadow_q;
        y_d      = y_q;
        co_d     = co_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.A;
                    b_d     = b_in;
                    carry_d = ci_in;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                shadow_d = merged;
                carry_d  = fa_co;
                cnt_d    = cnt_q + CW'(1);
                // Result registers change only here, so partial sums never leak out.
                if (cnt_q == CNT_LAST) begin
                    y_d     = merged;
                    co_d    = fa_co;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            shadow_q <= '0;
            y_q      <= '0;
            co_q     <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            shadow_q <= shadow_d;
            y_q      <= y_d;
            co_q     <= co_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.Y    = y_q;
    assign bus.Co   = co_q;

endmodule

// File: tb/tb_fa4_serial_add_ctrl.sv
// Directed and random checks of fa4_serial_add_ctrl at WIDTH=16 and WIDTH=4.
module tb_fa4_serial_add_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    fa4_serial_add_ctrl_if #(.WIDTH(16)) bus16 ();
    fa4_serial_add_ctrl_if #(.WIDTH(4))  bus4  ();

    fa4_serial_add_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(bus16.slave));
    fa4_serial_add_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .reset(reset), .bus(bus4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one add on the 16-bit unit; result must appear after exactly 4 run cycles.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic ci,
                          input logic [15:0] prev_y, input logic prev_co,
                          input logic [15:0] exp_y, input logic exp_co);
        int busy_cycles;
        bus16.A = a; bus16.B = b; bus16.Ci = ci; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        bus16.A = 16'h0F0F; bus16.B = 16'hF0F0; bus16.Ci = ~ci;
        busy_cycles = 0;
        for (int k = 1; k < 4; k++) begin
            if (bus16.busy) busy_cycles++;
            chk({tag, " hold"}, {bus16.done, bus16.Co, bus16.Y}, {1'b0, prev_co, prev_y});
            step();
        end
        if (bus16.busy) busy_cycles++;
        step();
        chk({tag, " busy_cycles"}, 64'(busy_cycles), 64'd4);
        chk({tag, " done"}, {bus16.done, bus16.busy}, 2'b10);
        chk({tag, " result"}, {bus16.Co, bus16.Y}, {exp_co, exp_y});
        step();
        chk({tag, " done_pulse"}, {bus16.done, bus16.busy, bus16.Co, bus16.Y}, {1'b0, 1'b0, exp_co, exp_y});
    endtask

    initial begin
        logic [16:0] exp17;
        logic [4:0]  exp5;
        logic [15:0] ra, rb;
        logic [3:0]  qa, qb;
        logic        rc;

        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Ci = 1'b0;
        bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.Ci  = 1'b0;
`ifdef FA4_SUB_EN
        bus16.sub = 1'b0;
        bus4.sub  = 1'b0;
`endif
        step();
        step();
        chk("reset16", {bus16.busy, bus16.done, bus16.Co, bus16.Y}, '0);
        chk("reset4",  {bus4.busy,  bus4.done,  bus4.Co,  bus4.Y},  '0);
        reset = 1'b0;
        step();

        run_op("ffff_plus_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
        run_op("1234_4321_c", 16'h1234, 16'h4321, 1'b1, 16'h0000, 1'b1, 16'h5556, 1'b0);

        // start held high: each new add is accepted in the done cycle of the previous one.
        bus16.A = 16'd1; bus16.B = 16'd1; bus16.Ci = 1'b0; bus16.start = 1'b1;
        step();
        bus16.A = 16'd2;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < 3; k++) begin
                chk("held no_done", {bus16.done, bus16.busy}, 2'b01);
                step();
            end
            step();
            chk("held done", {bus16.done, bus16.busy, bus16.Co, bus16.Y}, {2'b10, 1'b0, 16'(j + 2)});
            if (j == 2) bus16.start = 1'b0;
            step();
            chk("held reaccept", {bus16.done, bus16.busy}, (j == 2) ? 2'b00 : 2'b01);
            bus16.A = 16'(j + 3);
        end

        // A second start mid-run is dropped, not queued.
        bus16.A = 16'h1234; bus16.B = 16'h4321; bus16.Ci = 1'b1; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        step();
        step();
        bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.Ci = 1'b0; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        step();
        chk("ignore result", {bus16.done, bus16.Co, bus16.Y}, {1'b1, 1'b0, 16'h5556});
        step();
        chk("ignore no_queue", {bus16.done, bus16.busy}, 2'b00);

        // Reset mid-run.
        bus16.A = 16'h0001; bus16.B = 16'h0001; bus16.Ci = 1'b0; bus16.start = 1'b1;
        step();
        bus16.start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("midrun_reset", {bus16.busy, bus16.done, bus16.Co, bus16.Y}, '0);
        reset = 1'b0;
        step();
        step();
        chk("post_reset idle", {bus16.busy, bus16.done, bus16.Co, bus16.Y}, '0);
        run_op("after_reset", 16'h00F0, 16'h0F10, 1'b0, 16'h0000, 1'b0, 16'h1000, 1'b0);

`ifdef FA4_SUB_EN
        bus16.sub = 1'b1;
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b0, 16'h1000, 1'b0, 16'hFFFE, 1'b0);
        run_op("sub_9_2", 16'h0009, 16'h0002, 1'b0, 16'hFFFE, 1'b0, 16'h0007, 1'b1);
        bus16.sub = 1'b0;
`endif

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            exp17 = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            bus16.A = ra; bus16.B = rb; bus16.Ci = rc; bus16.start = 1'b1;
            step();
            bus16.start = 1'b0;
            bus16.A = ~ra;
            repeat (3) step();
            step();
            chk("rand16", {bus16.done, bus16.Co, bus16.Y}, {1'b1, exp17});
        end

        for (int i = 0; i < 1000; i++) begin
            qa = 4'($urandom);
            qb = 4'($urandom);
            rc = 1'($urandom);
            exp5 = {1'b0, qa} + {1'b0, qb} + {4'd0, rc};
            bus4.A = qa; bus4.B = qb; bus4.Ci = rc; bus4.start = 1'b1;
            step();
            bus4.start = 1'b0;
            bus4.B = ~qb;
            step();
            chk("rand4", {bus4.done, bus4.busy, bus4.Co, bus4.Y}, {2'b10, exp5});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
